// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: writes a generated pattern over an address window, reads it back,
// reports the first mismatch and interleaves refresh commands when the refresh timer expires.
module mem_pattern_tester #(
   parameter int FREQ           = 54_000_000,
   parameter int AW             = 25,
   parameter int DW             = 16,
   parameter int REFRESH_CYCLES = 422
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] length,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_wr,
   output logic          mem_rd,
   output logic          mem_refresh,
   input  logic [DW-1:0] mem_dout,
   input  logic          mem_data_ready,
   input  logic          mem_busy,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] err_addr,
   output logic [DW-1:0] err_expected,
   output logic [DW-1:0] err_actual,
   output logic [23:0]   refresh_count,
   output logic [7:0]    max_latency
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_ISSUE = 3'd1;
   localparam logic [2:0] WR_WAIT  = 3'd2;
   localparam logic [2:0] RD_ISSUE = 3'd3;
   localparam logic [2:0] RD_WAIT  = 3'd4;
   localparam logic [2:0] REF_WAIT = 3'd5;
   localparam logic [2:0] FINISH   = 3'd6;

   localparam int            TW      = $clog2(2 * REFRESH_CYCLES);
   localparam logic [TW-1:0] REF_INT = TW'(REFRESH_CYCLES);
   localparam logic [TW-1:0] TMR_MAX = TW'(2 * REFRESH_CYCLES - 1);

   if ((DW < 4) || (FREQ < 1) || (REFRESH_CYCLES < 1)) begin : g_bad_param
      $error("mem_pattern_tester: DW must be >= 4, FREQ and REFRESH_CYCLES positive");
   end

   // Expected data word for address a under pattern m
   function automatic logic [DW-1:0] pattern_f(input logic [1:0] m, input logic [AW-1:0] a);
      logic [AW+DW-1:0] ext_s;
      logic [DW-1:0]    xor_s;
      logic [DW-1:0]    chk_s;
      ext_s = {{DW{1'b0}}, a};
      xor_s = ext_s[DW-1:0] ^ DW'(ext_s >> DW);
      for (int i = 0; i < DW; i++) begin
         chk_s[i] = ((i % 2) == 0) ^ a[0];
      end
      case (m)
         2'd0:    return xor_s;
         2'd1:    return ~xor_s;
         2'd2:    return DW'(1'b1) << (a % AW'(DW));
         2'd3:    return chk_s;
         default: return xor_s;
      endcase
   endfunction

   logic [2:0]    state_r;
   logic [1:0]    mode_r;
   logic [AW-1:0] base_r;
   logic [AW-1:0] len_r;
   logic [AW-1:0] addr_r;
   logic [AW-1:0] cnt_r;
   logic          rd_phase_r;
   logic [TW-1:0] tmr_r;
   logic [7:0]    lat_r;
   logic          got_r;
   logic [DW-1:0] cap_r;

   logic [2:0]    state_nx_s;
   logic          issue_cmd_s;
   logic          issue_ref_s;
   logic          cmd_done_s;
   logic          mismatch_s;
   logic          wait_done_s;
   logic          last_s;
   logic          ref_needed_s;
   logic          have_s;
   logic          in_wait_s;
   logic [DW-1:0] exp_s;
   logic [DW-1:0] act_s;
   logic [TW-1:0] tmr_inc_s;
   logic [7:0]    lat_inc_s;

   // The strobe cycle itself never counts as completion, whatever mem_busy says
   assign wait_done_s  = !(mem_wr || mem_rd || mem_refresh) && !mem_busy;
   assign last_s       = (cnt_r == AW'(1'b1));
   assign ref_needed_s = (tmr_r >= REF_INT);
   assign exp_s        = pattern_f(mode_r, addr_r);
   assign have_s       = mem_data_ready || got_r;
   assign act_s        = mem_data_ready ? mem_dout : (got_r ? cap_r : {DW{1'b0}});
   assign in_wait_s    = (state_r == WR_WAIT) || (state_r == RD_WAIT) || (state_r == REF_WAIT);
   assign tmr_inc_s    = ((state_r != IDLE) && (state_r != FINISH) && (tmr_r != TMR_MAX)) ?
                         tmr_r + TW'(1'b1) : tmr_r;
   assign lat_inc_s    = (lat_r == 8'hFF) ? lat_r : lat_r + 8'd1;

   // Next-state and command decision
   always_comb begin
      state_nx_s  = state_r;
      issue_cmd_s = 1'b0;
      issue_ref_s = 1'b0;
      cmd_done_s  = 1'b0;
      mismatch_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = (length == {AW{1'b0}}) ? FINISH : WR_ISSUE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         WR_ISSUE, RD_ISSUE: begin
            if (mem_busy) begin
               state_nx_s = state_r;
            end else if (ref_needed_s) begin
               issue_ref_s = 1'b1;
               state_nx_s  = REF_WAIT;
            end else begin
               issue_cmd_s = 1'b1;
               state_nx_s  = (state_r == WR_ISSUE) ? WR_WAIT : RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (wait_done_s) begin
               cmd_done_s = 1'b1;
               state_nx_s = last_s ? RD_ISSUE : WR_ISSUE;
            end else begin
               state_nx_s = WR_WAIT;
            end
         end
         RD_WAIT: begin
            if (wait_done_s) begin
               cmd_done_s = 1'b1;
               mismatch_s = !have_s || (act_s != exp_s);
               state_nx_s = (mismatch_s || last_s) ? FINISH : RD_ISSUE;
            end else begin
               state_nx_s = RD_WAIT;
            end
         end
         REF_WAIT: begin
            if (wait_done_s) begin
               state_nx_s = rd_phase_r ? RD_ISSUE : WR_ISSUE;
            end else begin
               state_nx_s = REF_WAIT;
            end
         end
         FINISH:  state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Registered state, command strobes and status
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         mode_r        <= 2'd0;
         base_r        <= {AW{1'b0}};
         len_r         <= {AW{1'b0}};
         addr_r        <= {AW{1'b0}};
         cnt_r         <= {AW{1'b0}};
         rd_phase_r    <= 1'b0;
         tmr_r         <= {TW{1'b0}};
         lat_r         <= 8'd0;
         got_r         <= 1'b0;
         cap_r         <= {DW{1'b0}};
         mem_addr      <= {AW{1'b0}};
         mem_din       <= {DW{1'b0}};
         mem_wr        <= 1'b0;
         mem_rd        <= 1'b0;
         mem_refresh   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_addr      <= {AW{1'b0}};
         err_expected  <= {DW{1'b0}};
         err_actual    <= {DW{1'b0}};
         refresh_count <= 24'd0;
         max_latency   <= 8'd0;
      end else begin
         state_r     <= state_nx_s;
         busy        <= (state_nx_s != IDLE);
         done        <= (state_nx_s == FINISH);
         mem_wr      <= issue_cmd_s && !rd_phase_r;
         mem_rd      <= issue_cmd_s && rd_phase_r;
         mem_refresh <= issue_ref_s;
         tmr_r       <= issue_ref_s ? tmr_inc_s - REF_INT : tmr_inc_s;
         if ((state_r == IDLE) && start) begin
            mode_r        <= mode;
            base_r        <= base_addr;
            len_r         <= length;
            addr_r        <= base_addr;
            cnt_r         <= length;
            rd_phase_r    <= 1'b0;
            error         <= 1'b0;
            err_addr      <= {AW{1'b0}};
            err_expected  <= {DW{1'b0}};
            err_actual    <= {DW{1'b0}};
            refresh_count <= 24'd0;
            max_latency   <= 8'd0;
         end
         if (issue_cmd_s) begin
            mem_addr <= addr_r;
            if (!rd_phase_r) mem_din <= exp_s;
            got_r <= 1'b0;
         end
         if (issue_cmd_s || issue_ref_s) lat_r <= 8'd0;
         if (issue_ref_s) refresh_count <= refresh_count + 24'd1;
         if (in_wait_s && !wait_done_s) lat_r <= lat_inc_s;
         if ((state_r == RD_WAIT) && mem_data_ready) begin
            got_r <= 1'b1;
            cap_r <= mem_dout;
         end
         if (cmd_done_s) begin
            if (lat_r > max_latency) max_latency <= lat_r;
            if (last_s) begin
               addr_r     <= base_r;
               cnt_r      <= len_r;
               rd_phase_r <= 1'b1;
            end else begin
               addr_r <= addr_r + AW'(1'b1);
               cnt_r  <= cnt_r - AW'(1'b1);
            end
         end
         if (mismatch_s) begin
            error        <= 1'b1;
            err_addr     <= addr_r;
            err_expected <= exp_s;
            err_actual   <= act_s;
         end
      end
   end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Randomized self-checking bench for mem_pattern_tester with a behavioural memory controller
// and a pattern/scoreboard model computed directly from the addressing and pattern rules.
module tb_mem_pattern_tester;
   localparam int AW = 25;
   localparam int DW = 16;
   localparam int RC = 16;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [1:0]    mode;
   logic [AW-1:0] base_addr, length;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;
   logic          mem_wr, mem_rd, mem_refresh, mem_data_ready, mem_busy;
   logic          busy, done, error;
   logic [AW-1:0] err_addr;
   logic [DW-1:0] err_expected, err_actual;
   logic [23:0]   refresh_count;
   logic [7:0]    max_latency;

   always #5 clk = ~clk;

   mem_pattern_tester #(.FREQ(54_000_000), .AW(AW), .DW(DW), .REFRESH_CYCLES(RC)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr), .length(length),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_refresh(mem_refresh), .mem_dout(mem_dout), .mem_data_ready(mem_data_ready),
      .mem_busy(mem_busy), .busy(busy), .done(done), .error(error), .err_addr(err_addr),
      .err_expected(err_expected), .err_actual(err_actual), .refresh_count(refresh_count),
      .max_latency(max_latency));

   typedef struct packed {
      logic [1:0]    kind;   // 0 write, 1 read, 2 refresh
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [15:0]   n;      // busy cycles the controller model chose after the strobe
   } cmd_t;

   int n_cmp = 0;
   int n_err = 0;
   cmd_t          log_q[$];
   logic [DW-1:0] mem_m [logic [AW-1:0]];
   int            ref_pulses, busy_left;
   bit            rd_pend, rd_drop;
   logic [DW-1:0] rd_val;
   bit            lat_random, corrupt_en, noready_en, long_en;
   logic [AW-1:0] corrupt_addr, noready_addr, long_addr;
   logic [DW-1:0] corrupt_val;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_pattern(input int m, input logic [AW-1:0] a);
      longint        av;
      logic [DW-1:0] x;
      av = longint'(a);
      x  = DW'(av % 65536) ^ DW'(av / 65536);
      case (m)
         0:       return x;
         1:       return ~x;
         2:       return DW'(1) << (av % 16);
         default: return ((av % 2) == 0) ? 16'h5555 : 16'hAAAA;
      endcase
   endfunction

   function automatic int pick_n(input int kind, input logic [AW-1:0] a);
      if (long_en && kind == 1 && a == long_addr) return 300;
      else if (lat_random) return int'($urandom_range(0, 5));
      else return 3;
   endfunction

   task automatic present_data();
      if (rd_pend) begin
         if (!rd_drop) begin
            mem_data_ready = 1'b1;
            mem_dout       = rd_val;
         end
         rd_pend = 1'b0;
      end
   endtask

   // Behavioural controller: busy from the strobe cycle for n further cycles, read data in the last busy cycle
   initial begin
      logic prev_busy;
      int   kind, n;
      mem_busy = 1'b0; mem_data_ready = 1'b0; mem_dout = '0;
      busy_left = 0; rd_pend = 1'b0; rd_drop = 1'b0; rd_val = '0; ref_pulses = 0;
      forever begin
         @(posedge clk); #1;
         prev_busy      = mem_busy;
         mem_data_ready = 1'b0;
         if (reset) begin
            busy_left = 0; mem_busy = 1'b0; rd_pend = 1'b0;
         end else if (mem_wr || mem_rd || mem_refresh) begin
            check_eq("single_strobe", 64'(int'(mem_wr) + int'(mem_rd) + int'(mem_refresh)), 64'd1);
            check_eq("strobe_while_busy", prev_busy, 1'b0);
            kind = mem_wr ? 0 : (mem_rd ? 1 : 2);
            n    = pick_n(kind, mem_addr);
            log_q.push_back('{kind: 2'(kind), addr: mem_addr, din: mem_din, n: 16'(n)});
            if (mem_wr) mem_m[mem_addr] = mem_din;
            if (mem_refresh) ref_pulses++;
            if (mem_rd) begin
               rd_pend = 1'b1;
               rd_drop = noready_en && (mem_addr == noready_addr);
               if (corrupt_en && mem_addr == corrupt_addr) rd_val = corrupt_val;
               else rd_val = mem_m.exists(mem_addr) ? mem_m[mem_addr] : '0;
            end
            busy_left = n;
            mem_busy  = 1'b1;
            if (n == 0) present_data();
         end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) present_data();
         end else begin
            mem_busy = 1'b0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "/busy"}, busy, 1'b0);
      check_eq({tag, "/done"}, done, 1'b0);
      check_eq({tag, "/error"}, error, 1'b0);
      check_eq({tag, "/err_addr"}, err_addr, '0);
      check_eq({tag, "/err_expected"}, err_expected, '0);
      check_eq({tag, "/err_actual"}, err_actual, '0);
      check_eq({tag, "/mem_addr"}, mem_addr, '0);
      check_eq({tag, "/mem_din"}, mem_din, '0);
      check_eq({tag, "/strobes"}, {mem_wr, mem_rd, mem_refresh}, '0);
      check_eq({tag, "/refresh_count"}, refresh_count, '0);
      check_eq({tag, "/max_latency"}, max_latency, '0);
   endtask

   task automatic run_test(input string name, input int m, input logic [AW-1:0] b,
                           input logic [AW-1:0] l, input bit poke);
      cmd_t          exp_q[$];
      cmd_t          got_q[$];
      bit            exp_err, got_done;
      logic [AW-1:0] a, e_addr;
      logic [DW-1:0] p, act, e_exp, e_act;
      int            exp_ml, v;
      log_q.delete(); mem_m.delete(); ref_pulses = 0;
      @(negedge clk);
      mode = 2'(m); base_addr = b; length = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mode = 2'($urandom); base_addr = AW'($urandom); length = AW'($urandom);
      check_eq({name, "/busy_after_start"}, busy, 1'b1);
      got_done = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if (done) begin got_done = 1'b1; break; end
         start = poke && (c == 7);
         @(negedge clk);
      end
      start = 1'b0;
      check_eq({name, "/done_seen"}, got_done, 1'b1);
      @(negedge clk);
      check_eq({name, "/done_one_cycle"}, done, 1'b0);
      check_eq({name, "/idle_after"}, busy, 1'b0);
      // expected command stream and verdict from the addressing and pattern rules
      exp_err = 1'b0; e_addr = '0; e_exp = '0; e_act = '0;
      for (longint i = 0; i < longint'(l); i++) begin
         a = AW'(longint'(b) + i);
         exp_q.push_back('{kind: 2'd0, addr: a, din: ref_pattern(m, a), n: 16'd0});
      end
      for (longint i = 0; i < longint'(l); i++) begin
         a = AW'(longint'(b) + i);
         p = ref_pattern(m, a);
         exp_q.push_back('{kind: 2'd1, addr: a, din: '0, n: 16'd0});
         if (noready_en && a == noready_addr) begin
            exp_err = 1'b1; act = '0;
         end else begin
            act = (corrupt_en && a == corrupt_addr) ? corrupt_val : p;
            exp_err = (act != p);
         end
         if (exp_err) begin e_addr = a; e_exp = p; e_act = act; break; end
      end
      exp_ml = 0;
      foreach (log_q[i]) begin
         if (log_q[i].kind != 2'd2) begin
            got_q.push_back(log_q[i]);
            v = (int'(log_q[i].n) + 1 > 255) ? 255 : int'(log_q[i].n) + 1;
            if (v > exp_ml) exp_ml = v;
         end
      end
      check_eq({name, "/n_cmds"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check_eq($sformatf("%s/kind[%0d]", name, i), got_q[i].kind, exp_q[i].kind);
         check_eq($sformatf("%s/addr[%0d]", name, i), got_q[i].addr, exp_q[i].addr);
         if (exp_q[i].kind == 2'd0)
            check_eq($sformatf("%s/din[%0d]", name, i), got_q[i].din, exp_q[i].din);
      end
      check_eq({name, "/error"}, error, exp_err);
      check_eq({name, "/err_addr"}, err_addr, e_addr);
      check_eq({name, "/err_expected"}, err_expected, e_exp);
      check_eq({name, "/err_actual"}, err_actual, e_act);
      check_eq({name, "/refresh_count"}, refresh_count, ref_pulses);
      check_eq({name, "/max_latency"}, max_latency, exp_ml);
   endtask

   task automatic clear_knobs();
      lat_random = 1'b0; corrupt_en = 1'b0; noready_en = 1'b0; long_en = 1'b0;
      corrupt_addr = '0; noready_addr = '0; long_addr = '0; corrupt_val = '0;
   endtask

   initial begin
      int            m, l;
      logic [AW-1:0] b;
      bit            saw_rd;
      reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; length = '0;
      clear_knobs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("reset");

      run_test("m0_base0", 0, '0, 25'd4, 1'b0);
      check_eq("m0_base0/latency4", max_latency, 8'd4);
      run_test("m0_wrap", 0, 25'h1FFFFFE, 25'd4, 1'b0);

      corrupt_en = 1'b1; corrupt_addr = 25'd5; corrupt_val = 16'h0000;
      run_test("m2_corrupt5", 2, '0, 25'd20, 1'b0);
      check_eq("m2_corrupt5/err_expected", err_expected, 16'h0020);
      clear_knobs();

      noready_en = 1'b1; noready_addr = 25'd103;
      run_test("m3_noready", 3, 25'd100, 25'd8, 1'b0);
      clear_knobs();

      lat_random = 1'b1;
      run_test("m1_refresh64", 1, 25'd1000, 25'd64, 1'b0);
      check_eq("m1_refresh64/refreshes_seen", ref_pulses > 0, 1'b1);

      long_en = 1'b1; long_addr = 25'd7;
      run_test("m0_lat_sat", 0, 25'd5, 25'd4, 1'b0);
      clear_knobs();

      for (int r = 0; r < 6; r++) begin
         clear_knobs();
         lat_random = 1'b1;
         m = int'($urandom_range(0, 3));
         l = int'($urandom_range(1, 24));
         b = (r % 2 == 1) ? AW'((2 ** AW) - int'($urandom_range(1, 12))) : AW'($urandom);
         corrupt_en   = (r % 3 == 1);
         corrupt_addr = AW'(longint'(b) + longint'($urandom_range(0, l - 1)));
         corrupt_val  = ref_pattern(m, corrupt_addr) ^ DW'($urandom_range(1, 65535));
         noready_en   = (r == 4);
         noready_addr = AW'(longint'(b) + longint'($urandom_range(0, l - 1)));
         run_test($sformatf("rand%0d", r), m, b, AW'(l), 1'b1);
      end
      clear_knobs();

      // abandon a run in RD_WAIT; start coinciding with reset must lose
      log_q.delete();
      @(negedge clk);
      mode = 2'd1; base_addr = 25'd200; length = 25'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      saw_rd = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         foreach (log_q[i]) if (log_q[i].kind == 2'd1) saw_rd = 1'b1;
         if (saw_rd) break;
      end
      check_eq("rst_mid/reached_read", saw_rd, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check_reset_outputs("rst_mid");
      run_test("rst_len0", 0, 25'd50, '0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
